// File: rtl/spi_reg_bank.sv
// SPI-slave (mode 0) register bank holding the five PWM-stage control registers.
// Optional cipo readback of the addressed register is enabled by defining SPI_READBACK_EN.
module spi_reg_bank #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       frame_done,
    output logic       frame_err
);

    localparam int SL = SYNC_STAGES + 1;

    typedef enum logic [1:0] {IDLE, RECV, COMMIT} state_t;

    state_t        state;
    logic [SL-1:0] sclk_sync;
    logic [SL-1:0] copi_sync;
    logic [SL-1:0] ncs_sync;
    logic [4:0]    bit_cnt;
    logic [15:0]   shift_reg;
    logic          sclk_rise;
    logic          sclk_fall;
    logic          ncs_fall;
    logic          ncs_rise;
    logic          ncs_lvl;
    logic          copi_lvl;
    logic [6:0]    frame_addr;
    logic [15:0]   shift_next;

    // The ncs chain resets low so a chip select already asserted at reset release
    // produces no falling edge; a frame needs a fresh high-to-low transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SL-2:0], sclk};
            copi_sync <= {copi_sync[SL-2:0], copi};
            ncs_sync  <= {ncs_sync[SL-2:0], ncs};
        end
    end

    assign sclk_rise  = sclk_sync[SL-2] & ~sclk_sync[SL-1];
    assign sclk_fall  = ~sclk_sync[SL-2] & sclk_sync[SL-1];
    assign ncs_fall   = ~ncs_sync[SL-2] & ncs_sync[SL-1];
    assign ncs_rise   = ncs_sync[SL-2] & ~ncs_sync[SL-1];
    assign ncs_lvl    = ncs_sync[SL-2];
    assign copi_lvl   = copi_sync[SL-2];
    assign frame_addr = shift_reg[14:8];
    assign shift_next = {shift_reg[14:0], copi_lvl};

    function automatic logic [7:0] reg_read(input logic [6:0] addr);
        logic [7:0] val;
        val = 8'h00;
        if (addr <= MAX_ADDR) begin
            case (addr)
                7'h00:   val = en_reg_out_7_0;
                7'h01:   val = en_reg_out_15_8;
                7'h02:   val = en_reg_pwm_7_0;
                7'h03:   val = en_reg_pwm_15_8;
                7'h04:   val = pwm_duty_cycle;
                default: val = 8'h00;
            endcase
        end
        return val;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            shift_reg       <= '0;
            frame_done      <= 1'b0;
            frame_err       <= 1'b0;
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (ncs_fall) begin
                        state     <= RECV;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end
                end
                RECV: begin
                    if (ncs_rise) begin
                        state <= COMMIT;
                    end else if (sclk_rise) begin
                        shift_reg <= shift_next;
                        // Saturate at 17 so any overrun stays distinguishable from 16.
                        if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    if (bit_cnt == 5'd16 && frame_addr <= MAX_ADDR) begin
                        frame_done <= 1'b1;
                        if (shift_reg[15]) begin
                            case (frame_addr)
                                7'h00:   en_reg_out_7_0  <= shift_reg[7:0];
                                7'h01:   en_reg_out_15_8 <= shift_reg[7:0];
                                7'h02:   en_reg_pwm_7_0  <= shift_reg[7:0];
                                7'h03:   en_reg_pwm_15_8 <= shift_reg[7:0];
                                7'h04:   pwm_duty_cycle  <= shift_reg[7:0];
                                default: ;
                            endcase
                        end
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    logic [7:0] rd_shift;

    // The header completes on the 8th rise; the shifter is loaded then and
    // presents its MSB on the following sclk fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_shift <= 8'h00;
            cipo     <= 1'b0;
        end else if (ncs_lvl) begin
            rd_shift <= 8'h00;
            cipo     <= 1'b0;
        end else if (state == RECV && !ncs_rise) begin
            if (sclk_rise && bit_cnt == 5'd7 && !shift_next[7]) begin
                rd_shift <= reg_read(shift_next[6:0]);
            end else if (sclk_fall) begin
                cipo     <= rd_shift[7];
                rd_shift <= {rd_shift[6:0], 1'b0};
            end
        end
    end
`else
    assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Randomized bench for spi_reg_bank against a frame-level model of the register bank.
// Readback expectations follow the SPI_READBACK_EN define used for the build.
module tb_spi_reg_bank;

    localparam int SYNC = 2;
    localparam int HALF = 6;
`ifdef SPI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic       cipo;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       frame_done, frame_err;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] model [5];

    spi_reg_bank #(.SYNC_STAGES(SYNC), .MAX_ADDR(7'h04)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag, input logic [7:0] exp [5]);
        chk({tag, " out_7_0"},  {24'h0, en_reg_out_7_0},  {24'h0, exp[0]});
        chk({tag, " out_15_8"}, {24'h0, en_reg_out_15_8}, {24'h0, exp[1]});
        chk({tag, " pwm_7_0"},  {24'h0, en_reg_pwm_7_0},  {24'h0, exp[2]});
        chk({tag, " pwm_15_8"}, {24'h0, en_reg_pwm_15_8}, {24'h0, exp[3]});
        chk({tag, " duty"},     {24'h0, pwm_duty_cycle},  {24'h0, exp[4]});
    endtask

    function automatic logic [7:0] model_rd(input logic [6:0] a);
        return (a <= 7'd4) ? model[a[2:0]] : 8'h00;
    endfunction

    task automatic send_bit(input logic b);
        copi = b;
        repeat (HALF) @(negedge clk);
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
    endtask

    // Sends nbits of w MSB first (zeros past bit 16); ignored=1 means the DUT must not react.
    task automatic spi_frame(input logic [15:0] w, input int nbits, input bit ignored);
        logic [7:0] old [5];
        logic [7:0] rd;
        logic       exp_bit;
        bit         ok;
        int         dn, er, idx;
        old = model;
        rd  = model_rd(w[14:8]);
        @(negedge clk);
        ncs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            copi = (i < 16) ? w[15-i] : 1'b0;
            repeat (HALF) @(negedge clk);
            exp_bit = (RB && !ignored && !w[15] && i >= 8 && i < 16) ? rd[15-i] : 1'b0;
            if (i < 16) chk($sformatf("cipo bit%0d", i), {31'h0, cipo}, {31'h0, exp_bit});
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        ncs = 1'b1;
        dn = 0; er = 0; idx = -1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            if (e == SYNC + 1) check_regs("pre-commit", old);
            if (frame_done) begin dn++; idx = e; end
            if (frame_err) begin er++; idx = e; end
        end
        ok = (nbits == 16) && (w[14:8] <= 7'd4);
        if (!ignored && ok && w[15]) model[w[10:8]] = w[7:0];
        chk("frame_done count", dn, (!ignored && ok) ? 1 : 0);
        chk("frame_err count", er, (!ignored && !ok) ? 1 : 0);
        if (!ignored) chk("commit latency", idx, SYNC + 2);
        check_regs("post-frame", model);
        chk("cipo idle", {31'h0, cipo}, 32'h0);
    endtask

    initial begin
        logic [15:0] w;
        int          nb;
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_regs("reset", model);
        chk("reset cipo", {31'h0, cipo}, 32'h0);
        chk("reset done", {31'h0, frame_done}, 32'h0);
        chk("reset err", {31'h0, frame_err}, 32'h0);
        repeat (10) @(negedge clk);

        spi_frame(16'h80F0, 16, 1'b0);
        spi_frame(16'h8480, 16, 1'b0);
        spi_frame(16'h84FF, 16, 1'b0);
        spi_frame(16'h85AA, 16, 1'b0);
        spi_frame(16'h8133, 15, 1'b0);
        spi_frame(16'h8355, 17, 1'b0);
        spi_frame(16'h825A, 16, 1'b0);
        spi_frame(16'h0200, 16, 1'b0);

        // Reset pulse in the middle of a frame; the rest of that frame must be ignored.
        @(negedge clk);
        ncs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 8; i++) send_bit(i == 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        check_regs("mid-frame reset", model);
        spi_frame(16'h8477, 8, 1'b1);
        repeat (12) @(negedge clk);

        // nCS held low through reset release: no frame may start.
        ncs = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (HALF) @(negedge clk);
        spi_frame(16'h8011, 16, 1'b1);

        for (int k = 0; k < 24; k++) begin
            w = {$urandom_range(0, 1) == 1, 7'($urandom_range(0, 6)), 8'($urandom)};
            case ($urandom_range(0, 5))
                0:       nb = 15;
                1:       nb = 17;
                default: nb = 16;
            endcase
            spi_frame(w, nb, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

SPI-slave register bank that receives configuration frames from an external controller and holds the five control registers consumed by the PWM output stage: output enables, PWM enables and the PWM duty cycle. Runs in the `clk` domain. Oversamples the asynchronous SPI pins through synchronizers. Commits a register write only after a complete, well-formed frame.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops per SPI input (≥2).
- `MAX_ADDR`, 7'h04: highest valid register address; frames addressing above it are ignored.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `sclk`  in  1  SPI clock, asynchronous, mode 0.
- `copi`  in  1  SPI controller-out data, asynchronous.
- `ncs`  in  1  SPI chip select, active-low, asynchronous.
- `cipo`  out  1  SPI controller-in data (readback only).
- `en_reg_out_7_0`  out  8  reg 0x00, output enable bits 7:0.
- `en_reg_out_15_8`  out  8  reg 0x01, output enable bits 15:8.
- `en_reg_pwm_7_0`  out  8  reg 0x02, PWM enable bits 7:0.
- `en_reg_pwm_15_8`  out  8  reg 0x03, PWM enable bits 15:8.
- `pwm_duty_cycle`  out  8  reg 0x04, duty cycle (8'hFF = 100 %).
- `frame_done`  out  1  one-clk strobe: valid frame committed.
- `frame_err`  out  1  one-clk strobe: frame discarded (bad length or address).

## Operation
- Frame: 16 bits, MSB first, sampled on SCLK rising edge while nCS low.
  - Bit 15: R/W, 1 = write.
  - Bits 14:8: address.
  - Bits 7:0: data.
- `sclk`, `copi` and `ncs` each pass through `SYNC_STAGES` flops plus one history flop. Edges are detected from the last two stages. COPI is sampled from its synchronized value in the clk cycle where the SCLK rising edge is detected.
- FSM:
  - IDLE → RECV on detected nCS falling edge. Clear the 5-bit bit counter and the 16-bit shift register.
  - RECV: each detected SCLK rise shifts in COPI and increments the counter. The counter saturates at 17; ≥17 means overrun.
  - RECV → COMMIT on detected nCS rising edge.
  - COMMIT → IDLE after one cycle.
- COMMIT outcomes:
  - Write, address ≤ `MAX_ADDR`, count == 16: update the addressed register and pulse `frame_done`.
  - Read (bit 15 = 0), count == 16: pulse `frame_done` and change no register.
  - Count ≠ 16 or address > `MAX_ADDR`: pulse `frame_err` and change no register.
- SCLK edges while in IDLE are ignored.
- If nCS is low when reset releases, no frame starts until nCS goes high and then low again.
- Reset mid-frame clears everything and discards the frame.
- Registers hold their values indefinitely between frames. Only one register changes per frame.

## Timing
- Reset values: all five registers 8'h00, `cipo` 0, `frame_done` 0, `frame_err` 0.
- Input-to-detect latency: `SYNC_STAGES`+1 clk edges from the first clk edge that samples the new pin level.
- Register update: on the clk edge leaving COMMIT, i.e. `SYNC_STAGES`+2 edges after nCS rises. `frame_done` is high during that same cycle and the new value is visible on the next cycle.
- SPI constraints: SCLK high and low phases ≥ `SYNC_STAGES`+2 clk periods each. nCS setup to the first SCLK rise and hold after the last fall ≥ `SYNC_STAGES`+2 clk periods. nCS high time between frames ≥ `SYNC_STAGES`+3 clk periods.
- `frame_done` and `frame_err` never assert in the same cycle.

## Configuration
- `SPI_READBACK_EN` defined:
  - When bits 15:8 of a read frame are complete (count == 8, R/W == 0, address ≤ `MAX_ADDR`), load the addressed register into an 8-bit output shifter.
  - `cipo` drives bit 7 on the next detected SCLK falling edge and shifts left on each subsequent falling edge.
  - `cipo` returns to 0 when nCS is detected high.
  - Out-of-range read addresses return 8'h00.
- `SPI_READBACK_EN` undefined: `cipo` is tied to 0 and the output shifter is not instantiated. Read frames still complete with `frame_done` and have no effect.

## Test plan
- Reset, then write 0x80_F0 (addr 0, data F0) → `en_reg_out_7_0` = 8'hF0, one `frame_done` pulse, other registers 8'h00.
- Write addr 0x04 with 8'h80 → `pwm_duty_cycle` = 8'h80. Then write addr 0x04 with 8'hFF → 8'hFF. Register update lands `SYNC_STAGES`+2 clk after nCS rises.
- Write to addr 0x05 with data AA, and a 15-bit write frame → each produces one `frame_err` pulse; all registers unchanged.
- 17-bit frame with valid header and data → `frame_err` pulse, no update. Assert `rst_n` low for 1 clk mid-frame → all registers 8'h00 and the partial frame is ignored.
- With `SPI_READBACK_EN`: write addr 0x02 with 8'h5A, then read addr 0x02 → `cipo` drives bits 0,1,0,1,1,0,1,0 on SCLK rises 9–16.
- Without `SPI_READBACK_EN`: the same read frame → `cipo` stays 0 throughout and `frame_done` pulses.
